// File: rtl/tcb_lite_pkg.sv
// Shared TCB-Lite helpers: maximum-width lane/data types, size-to-lane-mask
// decoding and byte-order swapping used by subordinates.
package tcb_lite_pkg;

    localparam int unsigned TCB_BYT_MAX = 16;
    localparam int unsigned TCB_DAT_MAX = 8 * TCB_BYT_MAX;

    typedef logic [TCB_BYT_MAX-1:0] tcb_byt_t;
    typedef logic [TCB_DAT_MAX-1:0] tcb_dat_t;
    typedef logic [2:0]             tcb_siz_t;
    typedef logic [3:0]             tcb_off_t;

    // Lanes off .. off+2**siz-1 set; callers slice to their own lane count.
    function automatic tcb_byt_t tcb_lite_siz2byt(input tcb_siz_t siz, input tcb_off_t off);
        tcb_byt_t    msk;
        int unsigned lo;
        int unsigned hi;
        lo  = 32'(off);
        hi  = lo + (32'd1 << siz);
        msk = '0;
        for (int unsigned i = 0; i < TCB_BYT_MAX; i++) begin
            msk[i] = (i >= lo) && (i < hi);
        end
        return msk;
    endfunction

    // Reverse the lowest 2**siz bytes; siz=0 is the identity.
    function automatic tcb_dat_t tcb_lite_bswap(input tcb_dat_t dat, input tcb_siz_t siz);
        tcb_dat_t    res;
        int unsigned n;
        n   = 32'd1 << siz;
        n   = (n > TCB_BYT_MAX) ? TCB_BYT_MAX : n;
        res = dat;
        for (int unsigned i = 0; i < TCB_BYT_MAX; i++) begin
            if (i < n) begin
                res[8*i +: 8] = dat[8*(n-1-i) +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tcb_lite_rsp_dly.sv
// Response delay line: DLY stages of valid/rdt/err, with the output either
// holding the last response (HLD=1) or returning to zero (HLD=0) when idle.
module tcb_lite_rsp_dly #(
    parameter int unsigned DLY = 1,
    parameter int unsigned HLD = 1,
    parameter int unsigned DAT = 32
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_vld,
    input  logic [DAT-1:0] i_rdt,
    input  logic           i_err,
    output logic [DAT-1:0] o_rdt,
    output logic           o_err
);

    logic           w_vld;
    logic [DAT-1:0] w_rdt;
    logic           w_err;
    logic [DAT-1:0] r_hld_rdt;
    logic           r_hld_err;

    generate
        if (DLY == 0) begin : g_comb
            assign w_vld = i_vld;
            assign w_rdt = i_rdt;
            assign w_err = i_err;
        end else begin : g_pipe
            logic [DLY-1:0] r_vld;
            logic [DAT-1:0] r_rdt [DLY];
            logic [DLY-1:0] r_err;

            // Only the valid bits need reset; data is qualified by them.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= i_vld;
                    for (int unsigned i = 1; i < DLY; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_rdt[0] <= i_rdt;
                r_err[0] <= i_err;
                for (int unsigned i = 1; i < DLY; i++) begin
                    r_rdt[i] <= r_rdt[i-1];
                    r_err[i] <= r_err[i-1];
                end
            end

            assign w_vld = r_vld[DLY-1];
            assign w_rdt = r_rdt[DLY-1];
            assign w_err = r_err[DLY-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hld_rdt <= '0;
            r_hld_err <= 1'b0;
        end else if (w_vld) begin
            r_hld_rdt <= w_rdt;
            r_hld_err <= w_err;
        end
    end

    always_comb begin
        o_rdt = '0;
        o_err = 1'b0;
        if (w_vld) begin
            o_rdt = w_rdt;
            o_err = w_err;
        end else if (HLD != 0) begin
            o_rdt = r_hld_rdt;
            o_err = r_hld_err;
        end
    end

endmodule

// File: rtl/tcb_lite_sub_mem.sv
// TCB-Lite subordinate terminating requests into a byte-addressable memory,
// with lane steering, endian swap, error reporting and a delayed response.
module tcb_lite_sub_mem
    import tcb_lite_pkg::*;
#(
    parameter  int unsigned DLY     = 1,
    parameter  int unsigned HLD     = 1,
    parameter  int unsigned MOD     = 1,
    parameter  int unsigned ADR     = 32,
    parameter  int unsigned DAT     = 32,
    parameter  int unsigned CTL     = 1,
    parameter  int unsigned STS     = 1,
    parameter  int unsigned SIZ_MEM = 4096,
    localparam int unsigned BYT     = DAT / 8,
    localparam int unsigned BYW     = $clog2(BYT),
    localparam int unsigned SZW     = ($clog2(BYW + 1) > 0) ? $clog2(BYW + 1) : 1
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           vld,
    output logic           rdy,
    input  logic           req_lck,
    input  logic           req_ndn,
    input  logic           req_wen,
    input  logic           req_ren,
    input  logic [CTL-1:0] req_ctl,
    input  logic [ADR-1:0] req_adr,
    input  logic [SZW-1:0] req_siz,
    input  logic [BYT-1:0] req_byt,
    input  logic [DAT-1:0] req_wdt,
    output logic [DAT-1:0] rsp_rdt,
    output logic [STS-1:0] rsp_sts,
    output logic           rsp_err
);

    localparam int unsigned OFW = (BYW > 0) ? BYW : 1;
    localparam int unsigned MAW = $clog2(SIZ_MEM);
    localparam int unsigned WRD = SIZ_MEM / BYT;

    logic               w_trn;
    logic [MAW-BYW-1:0] w_idx;
    tcb_off_t           w_off;
    tcb_siz_t           w_siz;
    tcb_siz_t           w_bsz;
    tcb_siz_t           w_swz;
    logic               w_oor;
    logic               w_mis;
    logic               w_err;
    tcb_byt_t           w_lmsk;
    tcb_dat_t           w_wsw;
    tcb_dat_t           w_rsw;
    logic [BYT-1:0]     w_msk;
    logic [DAT-1:0]     w_wdt;
    logic [DAT-1:0]     w_word;
    logic [DAT-1:0]     w_rmsk;
    logic [DAT-1:0]     w_rsh;
    logic [DAT-1:0]     w_rdt;
    logic               w_unused;

    logic [DAT-1:0]     r_mem [WRD];

    // Never stalls; a transfer seen while in reset is dropped entirely.
    assign rdy   = 1'b1;
    assign w_trn = vld & rdy & ~rst;

    assign w_idx = req_adr[MAW-1:BYW];
    assign w_off = (BYW > 0) ? tcb_off_t'(req_adr[OFW-1:0]) : '0;
    assign w_siz = tcb_siz_t'(req_siz);

    assign w_oor = (ADR > MAW) ? ((req_adr >> MAW) != '0) : 1'b0;
    assign w_mis = (32'(w_siz) > BYW) ||
                   ((32'(w_off) & ((32'd1 << w_siz) - 32'd1)) != 32'd0);
    assign w_err = w_oor || ((MOD == 0) && w_mis);

    // Byte-enable mode swaps the whole word; size mode only the transfer.
    assign w_bsz = (MOD != 0) ? tcb_siz_t'(BYW) : w_siz;
    assign w_swz = req_ndn ? w_bsz : '0;

    assign w_lmsk = tcb_lite_siz2byt(w_siz, w_off);
    assign w_wsw  = tcb_lite_bswap(tcb_dat_t'(req_wdt), w_swz);
    assign w_msk  = (MOD != 0) ? req_byt : w_lmsk[BYT-1:0];
    assign w_wdt  = (MOD != 0) ? w_wsw[DAT-1:0] : (w_wsw[DAT-1:0] << (8 * w_off));

    always_ff @(posedge clk) begin
        if (w_trn && req_wen && !w_err) begin
            for (int unsigned i = 0; i < BYT; i++) begin
                if (w_msk[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdt[8*i +: 8];
                end
            end
        end
    end

    // Read sees the array before this cycle's write lands (read-before-write).
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_rmsk = '0;
        for (int unsigned i = 0; i < BYT; i++) begin
            w_rmsk[8*i +: 8] = w_msk[i] ? w_word[8*i +: 8] : 8'h00;
        end
    end

    assign w_rsh = (MOD != 0) ? w_rmsk : (w_rmsk >> (8 * w_off));
    assign w_rsw = tcb_lite_bswap(tcb_dat_t'(w_rsh), w_swz);
    assign w_rdt = (req_ren && !w_err) ? w_rsw[DAT-1:0] : '0;

    tcb_lite_rsp_dly #(
        .DLY (DLY),
        .HLD (HLD),
        .DAT (DAT)
    ) u_rsp_dly (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_trn),
        .i_rdt (w_rdt),
        .i_err (w_err),
        .o_rdt (rsp_rdt),
        .o_err (rsp_err)
    );

    assign rsp_sts  = '0;
    assign w_unused = ^{req_lck, req_ctl, req_byt, w_lmsk, w_wsw, w_rsw};

endmodule

// File: tb/tb_tcb_lite_sub_mem.sv
// Bench for tcb_lite_sub_mem: one byte-enable instance and three size-mode
// instances (DLY/HLD variants) checked every cycle against a byte-level model.
module tb_tcb_lite_sub_mem;

    localparam int unsigned SIZ_MEM = 4096;

    typedef struct packed {
        int          due;
        logic        err;
        logic [31:0] rdt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // byte-enable instance inputs/outputs
    logic        a_vld = 1'b0, a_ndn = 1'b0, a_wen = 1'b0, a_ren = 1'b0;
    logic [31:0] a_adr = '0, a_wdt = '0;
    logic [3:0]  a_byt = '0;
    logic [1:0]  a_siz = '0;
    logic        a_rdy, a_sts, a_err;
    logic [31:0] a_rdt;

    // shared size-mode inputs
    logic        s_vld = 1'b0, s_ndn = 1'b0, s_wen = 1'b0, s_ren = 1'b0;
    logic [31:0] s_adr = '0, s_wdt = '0;
    logic [1:0]  s_siz = '0;
    logic [3:0]  s_byt = 4'hF;
    logic        b_rdy, b_sts, b_err, c_rdy, c_sts, c_err, d_rdy, d_sts, d_err;
    logic [31:0] b_rdt, c_rdt, d_rdt;

    exp_t        q_a[$], q_b[$], q_c[$], q_d[$];
    logic [32:0] last_a = '0, last_b = '0, last_c = '0, last_d = '0;
    logic [7:0]  mem_a [SIZ_MEM];
    logic [7:0]  mem_s [SIZ_MEM];

    tcb_lite_sub_mem #(.DLY(1), .HLD(1), .MOD(1)) u_a (
        .clk(clk), .rst(rst), .vld(a_vld), .rdy(a_rdy), .req_lck(1'b0), .req_ndn(a_ndn),
        .req_wen(a_wen), .req_ren(a_ren), .req_ctl(1'b0), .req_adr(a_adr), .req_siz(a_siz),
        .req_byt(a_byt), .req_wdt(a_wdt), .rsp_rdt(a_rdt), .rsp_sts(a_sts), .rsp_err(a_err));

    tcb_lite_sub_mem #(.DLY(2), .HLD(0), .MOD(0)) u_b (
        .clk(clk), .rst(rst), .vld(s_vld), .rdy(b_rdy), .req_lck(1'b0), .req_ndn(s_ndn),
        .req_wen(s_wen), .req_ren(s_ren), .req_ctl(1'b0), .req_adr(s_adr), .req_siz(s_siz),
        .req_byt(s_byt), .req_wdt(s_wdt), .rsp_rdt(b_rdt), .rsp_sts(b_sts), .rsp_err(b_err));

    tcb_lite_sub_mem #(.DLY(2), .HLD(1), .MOD(0)) u_c (
        .clk(clk), .rst(rst), .vld(s_vld), .rdy(c_rdy), .req_lck(1'b0), .req_ndn(s_ndn),
        .req_wen(s_wen), .req_ren(s_ren), .req_ctl(1'b0), .req_adr(s_adr), .req_siz(s_siz),
        .req_byt(s_byt), .req_wdt(s_wdt), .rsp_rdt(c_rdt), .rsp_sts(c_sts), .rsp_err(c_err));

    tcb_lite_sub_mem #(.DLY(0), .HLD(1), .MOD(0)) u_d (
        .clk(clk), .rst(rst), .vld(s_vld), .rdy(d_rdy), .req_lck(1'b0), .req_ndn(s_ndn),
        .req_wen(s_wen), .req_ren(s_ren), .req_ctl(1'b0), .req_adr(s_adr), .req_siz(s_siz),
        .req_byt(s_byt), .req_wdt(s_wdt), .rsp_rdt(d_rdt), .rsp_sts(d_sts), .rsp_err(d_err));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_rsp(input string tag, input bit due, input exp_t e, input bit hld,
                           inout logic [32:0] last, input logic [31:0] rdt, input logic err);
        if (due) last = {e.err, e.rdt};
        check(due ? {tag, "_rsp"} : {tag, "_idle"}, 64'({err, rdt}),
              64'((due || hld) ? last : 33'd0));
    endtask

    function automatic void model_a(input logic wen, ren, ndn, input logic [31:0] adr,
                                    input logic [3:0] byt, input logic [31:0] wdt,
                                    output logic err, output logic [31:0] rdt);
        int base, ln;
        err = (adr >= 32'(SIZ_MEM));
        rdt = '0;
        if (err) return;
        base = int'(adr & ~32'h3);
        if (ren) begin
            for (int k = 0; k < 4; k++) begin
                ln = ndn ? 3 - k : k;
                if (byt[ln]) rdt[8*k +: 8] = mem_a[base + ln];
            end
        end
        if (wen) begin
            for (int i = 0; i < 4; i++) begin
                if (byt[i]) mem_a[base + i] = wdt[8*(ndn ? 3 - i : i) +: 8];
            end
        end
    endfunction

    function automatic void model_s(input logic wen, ren, ndn, input logic [31:0] adr,
                                    input logic [1:0] siz, input logic [31:0] wdt,
                                    output logic err, output logic [31:0] rdt);
        int n, off, a;
        n   = 1 << siz;
        off = int'(adr & 32'h3);
        err = (adr >= 32'(SIZ_MEM)) || (siz == 2'd3) || ((off % n) != 0);
        rdt = '0;
        if (err) return;
        a = int'(adr);
        if (ren) for (int k = 0; k < n; k++) rdt[8*k +: 8] = mem_s[a + (ndn ? n - 1 - k : k)];
        if (wen) for (int k = 0; k < n; k++) mem_s[a + (ndn ? n - 1 - k : k)] = wdt[8*k +: 8];
    endfunction

    task automatic drv_a(input logic wen, ren, ndn, input logic [31:0] adr,
                         input logic [3:0] byt, input logic [31:0] wdt);
        logic err;
        logic [31:0] rdt;
        @(posedge clk); #1;
        s_vld = 1'b0;
        a_vld = 1'b1; a_wen = wen; a_ren = ren; a_ndn = ndn;
        a_adr = adr; a_byt = byt; a_wdt = wdt;
        model_a(wen, ren, ndn, adr, byt, wdt, err, rdt);
        q_a.push_back('{due: cyc + 1, err: err, rdt: rdt});
    endtask

    task automatic drv_s(input logic wen, ren, ndn, input logic [31:0] adr,
                         input logic [1:0] siz, input logic [31:0] wdt);
        logic err;
        logic [31:0] rdt;
        @(posedge clk); #1;
        a_vld = 1'b0;
        s_vld = 1'b1; s_wen = wen; s_ren = ren; s_ndn = ndn;
        s_adr = adr; s_siz = siz; s_wdt = wdt;
        model_s(wen, ren, ndn, adr, siz, wdt, err, rdt);
        q_b.push_back('{due: cyc + 2, err: err, rdt: rdt});
        q_c.push_back('{due: cyc + 2, err: err, rdt: rdt});
        q_d.push_back('{due: cyc, err: err, rdt: rdt});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            a_vld = 1'b0;
            s_vld = 1'b0;
        end
    endtask

    // Optionally presents a write during reset; the model never applies it.
    task automatic do_reset(input int ncyc, input bit wr_during);
        @(posedge clk); #1;
        rst   = 1'b1;
        a_vld = 1'b0;
        s_vld = wr_during;
        s_wen = 1'b1; s_ren = 1'b1; s_ndn = 1'b0;
        s_adr = 32'h30; s_siz = 2'd2; s_wdt = 32'hFFFF_FFFF;
        q_a.delete(); q_b.delete(); q_c.delete(); q_d.delete();
        last_a = '0; last_b = '0; last_c = '0; last_d = '0;
        repeat (ncyc) begin @(posedge clk); #1; end
        rst   = 1'b0;
        s_vld = 1'b0;
        #4;
        check("rdy", 64'({a_rdy, b_rdy, c_rdy, d_rdy}), 64'h0F);
        check("sts", 64'({a_sts, b_sts, c_sts, d_sts}), 64'h00);
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   due;
        if (chk_en && !rst) begin
            due = (q_a.size() > 0) && (q_a[0].due == cyc); e = '0;
            if (due) e = q_a.pop_front();
            chk_rsp("a", due, e, 1'b1, last_a, a_rdt, a_err);
            due = (q_b.size() > 0) && (q_b[0].due == cyc); e = '0;
            if (due) e = q_b.pop_front();
            chk_rsp("b", due, e, 1'b0, last_b, b_rdt, b_err);
            due = (q_c.size() > 0) && (q_c[0].due == cyc); e = '0;
            if (due) e = q_c.pop_front();
            chk_rsp("c", due, e, 1'b1, last_c, c_rdt, c_err);
            due = (q_d.size() > 0) && (q_d[0].due == cyc); e = '0;
            if (due) e = q_d.pop_front();
            chk_rsp("d", due, e, 1'b1, last_d, d_rdt, d_err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] adr;
        logic [1:0]  siz;
        do_reset(2, 1'b0);
        chk_en = 1'b1;

        for (int i = 0; i < 32; i++) drv_a(1'b1, 1'b0, 1'b0, 32'(4 * i), 4'hF, $urandom);
        for (int i = 0; i < 16; i++) drv_s(1'b1, 1'b0, 1'b0, 32'(4 * i), 2'd2, 32'h0);

        // byte-enable instance
        drv_a(1'b1, 1'b0, 1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF);
        drv_a(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        drv_a(1'b0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h0);
        drv_a(1'b1, 1'b1, 1'b0, 32'h10, 4'b0101, 32'h1122_3344);
        drv_a(1'b0, 1'b1, 1'b0, 32'h12, 4'hF, 32'h0);
        drv_a(1'b0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0);
        drv_a(1'b1, 1'b0, 1'b0, 32'h1000, 4'hF, 32'h5555_5555);
        drv_a(1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        idle(2);
        for (int i = 0; i < 24; i++) begin
            adr = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 127))
                                              : 32'($urandom_range(0, 127));
            drv_a(1'($urandom), 1'($urandom), 1'($urandom), adr, 4'($urandom), $urandom);
        end
        idle(2);

        // size-mode instances
        drv_s(1'b1, 1'b0, 1'b0, 32'h13, 2'd0, 32'hA5);
        drv_s(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0);
        drv_s(1'b0, 1'b1, 1'b0, 32'h13, 2'd0, 32'h0);
        drv_s(1'b1, 1'b0, 1'b1, 32'h20, 2'd1, 32'h1234);
        drv_s(1'b0, 1'b1, 1'b0, 32'h20, 2'd1, 32'h0);
        drv_s(1'b0, 1'b1, 1'b0, 32'h1000, 2'd2, 32'h0);
        drv_s(1'b1, 1'b0, 1'b0, 32'h0, 2'd2, 32'hCAFE_F00D);
        drv_s(1'b1, 1'b0, 1'b0, 32'h2, 2'd2, 32'hFFFF_FFFF);
        drv_s(1'b0, 1'b1, 1'b0, 32'h0, 2'd2, 32'h0);
        drv_s(1'b0, 1'b1, 1'b0, 32'h4, 2'd3, 32'h0);
        drv_s(1'b1, 1'b1, 1'b0, 32'h8, 2'd2, 32'h0102_0304);
        drv_s(1'b0, 1'b1, 1'b1, 32'h8, 2'd2, 32'h0);
        idle(3);
        for (int i = 0; i < 32; i++) begin
            siz = 2'($urandom_range(0, 3));
            adr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) adr = adr & ~((32'd1 << siz) - 32'd1);
            drv_s(1'($urandom), 1'($urandom), 1'($urandom), adr, siz, $urandom);
        end
        idle(4);

        // back-to-back reads, then idle so HLD=0 and HLD=1 diverge
        for (int i = 0; i < 4; i++) drv_s(1'b0, 1'b1, 1'b0, 32'(4 * i), 2'd2, 32'h0);
        idle(5);

        // reset with two reads in flight and a write presented during reset
        drv_s(1'b0, 1'b1, 1'b0, 32'h20, 2'd1, 32'h0);
        drv_s(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0);
        do_reset(1, 1'b1);
        idle(4);
        drv_s(1'b0, 1'b1, 1'b0, 32'h20, 2'd1, 32'h0);
        drv_s(1'b0, 1'b1, 1'b0, 32'h30, 2'd2, 32'h0);
        drv_s(1'b0, 1'b1, 1'b0, 32'h0, 2'd2, 32'h0);
        drv_a(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        idle(5);

        check("drain", 64'(q_a.size() + q_b.size() + q_c.size() + q_d.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tcb_lite_sub_mem.md
Name: tcb_lite_sub_mem

Overview:
- TCB-Lite subordinate (responder) that terminates a manager's request stream into a byte-addressable synchronous memory.
- Serves as the standard bus target for CPU/DMA testbenches and small on-chip RAMs.
- Implements the configured response delay (DLY), response hold (HLD), both bus modes (logarithmic size / byte enable), endianness swap and out-of-range error reporting.

Parameters:
- DLY, 1, response delay in cycles from transfer to response; 0 means combinational read.
- HLD, 1, 1: rsp holds the last response between responses; 0: rsp is driven to zero when no response is due.
- MOD, 1, bus mode; 0: logarithmic size (siz), 1: byte enable (byt).
- ADR, 32, address width.
- DAT, 32, data width; must be 8, 16, 32, 64 or 128.
- CTL, 1, control width; accepted and ignored.
- STS, 1, status width; always driven to zero.
- SIZ_MEM, 4096, memory size in bytes; must be a power of two and a multiple of DAT/8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- vld  in  1  request valid
- rdy  out  1  request ready
- req_lck  in  1  arbitration lock (ignored)
- req_ndn  in  1  endianness (0-little, 1-big)
- req_wen  in  1  write enable
- req_ren  in  1  read enable
- req_ctl  in  CTL  user control (ignored)
- req_adr  in  ADR  byte address
- req_siz  in  clog2(clog2(DAT/8)+1)  logarithmic transfer size (MOD=0)
- req_byt  in  DAT/8  byte enable (MOD=1)
- req_wdt  in  DAT  write data
- rsp_rdt  out  DAT  read data
- rsp_sts  out  STS  status (always 0)
- rsp_err  out  1  error

Behaviour:
- rdy is tied to 1; the block never stalls. trn = vld & rdy.
- Word index is adr[log2(SIZ_MEM)-1 : log2(BYT)]; off = adr[log2(BYT)-1:0].
- err = trn & (adr >= SIZ_MEM | (MOD==0 & off not aligned to 2**siz)).
- An errored request performs no write and returns rdt = 0.
- MOD=1: lane i is written when byt[i] & wen. Read returns the full word; lanes with byt[i]=0 are zero in rdt. adr is used word-aligned; off is ignored for alignment.
- MOD=0: data is LSB-aligned on wdt/rdt (bytes 0..2**siz-1).
  - Write: rotate wdt left by off bytes; enable lanes off..off+2**siz-1.
  - Read: select lanes off..off+2**siz-1 and shift them down to LSB; upper bytes are 0.
  - siz > log2(BYT) is treated as misaligned and returns err.
- ndn=1: byte order is reversed within the 2**siz transfer (MOD=0) or within the full word (MOD=1), applied before the write and after the read.
- wen & ren in the same transfer: the write occurs and the read returns the pre-write data.
- Write at cycle N followed by a read of the same address at N+1: the read returns the new data.
- Memory write happens at the posedge that ends the transfer cycle. The read is registered at that same edge.
- Response timing:
  - DLY=0: rsp is combinational from req in the trn cycle.
  - DLY>=1: rsp becomes valid DLY cycles after trn (one-cycle read plus a DLY-1 stage pipeline of rdt/err/valid).
- HLD=1: rsp_rdt and rsp_err keep the last response until the next response is due.
- HLD=0: when no response is due, rsp_rdt=0 and rsp_err=0.
- Back-to-back transfers every cycle yield responses every cycle, with no bubbles.
- Reset:
  - The delay pipeline valid bits clear; rsp_rdt=0, rsp_err=0, rsp_sts=0.
  - Memory contents are not reset.
  - Transfers in flight when rst asserts produce no response.
  - A trn in a cycle with rst=1 is discarded: no write, no response.

Decomposition:
- tcb_lite_pkg (shared package) gains:
  - function tcb_lite_siz2byt(siz, off) returning the lane mask;
  - function tcb_lite_bswap(data, siz) for the endian swap.
- One natural sub-module: tcb_lite_rsp_dly, a DLY-stage valid/rdt/err pipeline with HLD handling, reusable by other subordinates.
- The memory array, byte-lane steering and error logic live in tcb_lite_sub_mem.

Test Plan:
- DLY=1, MOD=1, DAT=32: write 0xDEADBEEF to adr 0x10 with byt=4'b1111, then read 0x10 -> rsp_rdt=0xDEADBEEF exactly 1 cycle after the read trn, err=0.
- MOD=0, DAT=32: write siz=0, adr=0x13, wdt=0xA5; read siz=2 at 0x10 -> rdt[31:24]=0xA5. Read siz=0 at 0x13 -> rdt=0x000000A5.
- MOD=0: write 0x1234 with siz=1, ndn=1 at 0x20; read siz=1, ndn=0 at 0x20 -> rdt=0x3412.
- Error cases:
  - read adr=SIZ_MEM (0x1000) -> err=1, rdt=0;
  - MOD=0 write siz=2 at 0x02 -> err=1, and the memory at 0x00 is unchanged.
- DLY=2, HLD=0: 4 back-to-back reads -> 4 consecutive response cycles starting 2 cycles after the first trn, then rdt=0. Repeat with HLD=1 -> the last rdt persists.
- Reset during 2 in-flight reads (DLY=2) -> no response is emitted, rsp_rdt=0 and err=0 from the cycle after rst. Data written before the reset reads back intact.
